// File: rtl/delay_align_pkg.sv
// Shared definitions for the delay-and-sum front end: FSM encoding, default
// widths and the channel-slice helper that the summer also uses.
package delay_align_pkg;

  localparam int DEF_DATA_WIDTH   = 16;
  localparam int DEF_NUM_CHANNELS = 4;
  localparam int DEF_MAX_DELAY    = 64;
  localparam int DEF_DELAY_WIDTH  = $clog2(DEF_MAX_DELAY);
  localparam int DEF_LEN_WIDTH    = 16;
  localparam int DEF_DATA_BUS     = DEF_NUM_CHANNELS * DEF_DATA_WIDTH;
  localparam int DEF_DELAY_BUS    = DEF_NUM_CHANNELS * DEF_DELAY_WIDTH;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    STREAM = 2'd2
  } state_t;

  // Low bit of channel ch inside a bus packed as ch*width.
  function automatic int ch_lsb(input int ch, input int width);
    return ch * width;
  endfunction

endpackage

// File: rtl/delay_ram.sv
// Single-channel circular sample buffer: synchronous write port and a
// combinational read port, so the top can pick any past sample in one cycle.
module delay_ram #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 64,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/delay_align.sv
// Per-channel programmable delay stage: buffers samples per channel and emits
// time-aligned sample sets once every channel's delay line holds valid data.
module delay_align
  import delay_align_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int NUM_CHANNELS = DEF_NUM_CHANNELS,
  parameter int MAX_DELAY    = DEF_MAX_DELAY,
  parameter int DELAY_WIDTH  = $clog2(MAX_DELAY),
  parameter int LEN_WIDTH    = DEF_LEN_WIDTH
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                start,
  input  logic [NUM_CHANNELS*DELAY_WIDTH-1:0] delay_cfg,
  input  logic [LEN_WIDTH-1:0]                line_len,
  input  logic                                sample_valid,
  input  logic [NUM_CHANNELS*DATA_WIDTH-1:0]  sample_in,
  output logic [NUM_CHANNELS*DATA_WIDTH-1:0]  delayed_sample,
  output logic                                sum_en,
  output logic                                start_sum,
  output logic                                busy,
  output logic                                done
);

  state_t state, state_next;

  logic [DELAY_WIDTH-1:0] d_r [NUM_CHANNELS];
  logic [DELAY_WIDTH-1:0] dmax_r, cfg_max;
  logic [DELAY_WIDTH-1:0] wr_ptr, fill_cnt;
  logic [LEN_WIDTH-1:0]   len_r, out_cnt;
  logic                   accept, emit, last, done_next, busy_next;
  logic [NUM_CHANNELS*DATA_WIDTH-1:0] aligned;

  always_comb begin
    cfg_max = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (delay_cfg[i*DELAY_WIDTH +: DELAY_WIDTH] > cfg_max)
        cfg_max = delay_cfg[i*DELAY_WIDTH +: DELAY_WIDTH];
    end
  end

  // Zero-delay channels bypass the RAM, whose read would return the old word.
  for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
    logic [DATA_WIDTH-1:0]  rd_data;
    logic [DELAY_WIDTH-1:0] rd_addr;

    assign rd_addr = wr_ptr - d_r[i];

    delay_ram #(
      .DATA_WIDTH(DATA_WIDTH),
      .DEPTH     (MAX_DELAY),
      .ADDR_WIDTH(DELAY_WIDTH)
    ) u_ram (
      .clk    (clk),
      .wr_en  (accept),
      .wr_addr(wr_ptr),
      .wr_data(sample_in[ch_lsb(i, DATA_WIDTH) +: DATA_WIDTH]),
      .rd_addr(rd_addr),
      .rd_data(rd_data)
    );

    assign aligned[ch_lsb(i, DATA_WIDTH) +: DATA_WIDTH] =
      (d_r[i] == '0) ? sample_in[ch_lsb(i, DATA_WIDTH) +: DATA_WIDTH] : rd_data;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    emit       = 1'b0;
    done_next  = 1'b0;
    last       = (out_cnt == len_r - 1'b1);
    case (state)
      IDLE: begin
        if (start) begin
          if (line_len == '0)      done_next  = 1'b1;
          else if (cfg_max == '0)  state_next = STREAM;
          else                     state_next = FILL;
        end
      end
      FILL: begin
        if (sample_valid) begin
          accept = 1'b1;
          if (fill_cnt == dmax_r) begin
            emit = 1'b1;
            if (last) begin
              done_next  = 1'b1;
              state_next = IDLE;
            end else begin
              state_next = STREAM;
            end
          end
        end
      end
      STREAM: begin
        if (sample_valid) begin
          accept = 1'b1;
          emit   = 1'b1;
          if (last) begin
            done_next  = 1'b1;
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
    // busy stays up through the done cycle of a real line, never for len==0.
    busy_next = (state_next != IDLE) || (done_next && (state != IDLE));
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state          <= IDLE;
      delayed_sample <= '0;
      sum_en         <= 1'b0;
      start_sum      <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      wr_ptr         <= '0;
      fill_cnt       <= '0;
      out_cnt        <= '0;
    end else begin
      state     <= state_next;
      sum_en    <= emit;
      start_sum <= emit && (out_cnt == '0);
      done      <= done_next;
      busy      <= busy_next;
      if (state == IDLE && start) begin
        for (int i = 0; i < NUM_CHANNELS; i++)
          d_r[i] <= delay_cfg[i*DELAY_WIDTH +: DELAY_WIDTH];
        dmax_r   <= cfg_max;
        len_r    <= line_len;
        fill_cnt <= '0;
        out_cnt  <= '0;
      end
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (accept && !emit) fill_cnt <= fill_cnt + 1'b1;
      if (emit) begin
        delayed_sample <= aligned;
        out_cnt        <= out_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_delay_align.sv
// Scoreboard bench for delay_align: a history-based reference model queues
// expected aligned outputs; a negedge monitor pops and compares them.
module tb_delay_align;
  import delay_align_pkg::*;

  localparam int DW = DEF_DATA_WIDTH;
  localparam int NC = DEF_NUM_CHANNELS;
  localparam int KW = DEF_DELAY_WIDTH;

  typedef struct {
    logic [NC*DW-1:0] data;
    bit               first;
    bit               last;
    int               cyc;
  } exp_t;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               start = 1'b0;
  logic [NC*KW-1:0]   delay_cfg = '0;
  logic [15:0]        line_len = '0;
  logic               sample_valid = 1'b0;
  logic [NC*DW-1:0]   sample_in = '0;
  logic [NC*DW-1:0]   delayed_sample;
  logic               sum_en, start_sum, busy, done;

  delay_align dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .delay_cfg     (delay_cfg),
    .line_len      (line_len),
    .sample_valid  (sample_valid),
    .sample_in     (sample_in),
    .delayed_sample(delayed_sample),
    .sum_en        (sum_en),
    .start_sum     (start_sum),
    .busy          (busy),
    .done          (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;
  bit mon_on = 0;
  bit chk_busy_low = 0;
  logic [NC*DW-1:0] last_out = '0;

  exp_t exp_q[$];
  int   lone_done_q[$];

  // Reference model: the line's accepted samples, oldest first.
  logic [NC*DW-1:0] hist[$];
  bit               m_active = 0;
  int               m_d[NC];
  int               m_dmax = 0;
  int               m_len = 0;
  int               m_outs = 0;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      if (chk_busy_low) check_output("busy_drop", busy, 0);
      chk_busy_low = 0;
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        exp_t e;
        e = exp_q.pop_front();
        check_output("sum_en", sum_en, 1);
        check_output("data", delayed_sample, e.data);
        check_output("start_sum", start_sum, e.first);
        check_output("done", done, e.last);
        check_output("busy", busy, 1);
        last_out = e.data;
        if (e.last) chk_busy_low = 1;
      end else begin
        if (sum_en) check_output("spurious_sum_en", sum_en, 0);
        if (start_sum) check_output("spurious_start_sum", start_sum, 0);
        if (delayed_sample !== last_out) check_output("hold_data", delayed_sample, last_out);
        if (lone_done_q.size() > 0 && lone_done_q[0] == cyc) begin
          void'(lone_done_q.pop_front());
          check_output("lone_done", done, 1);
          check_output("lone_busy", busy, 0);
        end else if (done) begin
          check_output("spurious_done", done, 0);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic apply_start(input logic [NC*KW-1:0] cfg, input logic [15:0] len);
    start = 1'b1;
    delay_cfg = cfg;
    line_len = len;
    if (!m_active) begin
      hist.delete();
      m_outs = 0;
      m_len = int'(len);
      m_dmax = 0;
      for (int c = 0; c < NC; c++) begin
        m_d[c] = int'(cfg[c*KW +: KW]);
        if (m_d[c] > m_dmax) m_dmax = m_d[c];
      end
      if (len == 0) lone_done_q.push_back(cyc + 1);
      else m_active = 1;
    end
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic apply_sample(input logic [NC*DW-1:0] s);
    sample_valid = 1'b1;
    sample_in = s;
    if (m_active) begin
      int k;
      hist.push_back(s);
      k = hist.size() - 1;
      if (k >= m_dmax) begin
        exp_t e;
        for (int c = 0; c < NC; c++) e.data[c*DW +: DW] = hist[k - m_d[c]][c*DW +: DW];
        e.first = (m_outs == 0);
        m_outs++;
        e.last = (m_outs == m_len);
        e.cyc = cyc + 1;
        exp_q.push_back(e);
        if (e.last) m_active = 0;
      end
    end
    @(posedge clk);
    #1;
    sample_valid = 1'b0;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    m_active = 0;
    last_out = '0;
    check_output("rst_data", delayed_sample, 0);
    check_output("rst_sum_en", sum_en, 0);
    check_output("rst_start_sum", start_sum, 0);
    check_output("rst_busy", busy, 0);
    check_output("rst_done", done, 0);
  endtask

  function automatic logic [NC*DW-1:0] ramp(input int n);
    logic [NC*DW-1:0] s;
    for (int c = 0; c < NC; c++) s[c*DW +: DW] = DW'(16 * c + n);
    return s;
  endfunction

  function automatic logic [NC*DW-1:0] rnd_sample();
    return {$urandom, $urandom};
  endfunction

  localparam logic [NC*KW-1:0] CFG_3210 = {6'd3, 6'd2, 6'd1, 6'd0};

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset = 1'b0;
    idle(3);
    reset = 1'b1;
    check_output("init_data", delayed_sample, 0);
    check_output("init_sum_en", sum_en, 0);
    check_output("init_busy", busy, 0);
    check_output("init_done", done, 0);
    mon_on = 1;

    apply_start(CFG_3210, 16'd4);
    for (int n = 0; n < 10; n++) apply_sample(ramp(n));
    idle(3);

    apply_start('0, 16'd2);
    for (int n = 0; n < 3; n++) apply_sample(rnd_sample());
    idle(3);

    apply_start({NC{6'd63}}, 16'd70);
    for (int n = 0; n < 133; n++) apply_sample(rnd_sample());
    idle(3);

    apply_start(CFG_3210, 16'd4);
    for (int n = 0; n < 10; n++) begin
      apply_sample(ramp(n));
      idle(3);
    end

    apply_start('0, 16'd5);
    apply_sample(rnd_sample());
    apply_sample(rnd_sample());
    apply_reset();
    apply_start('0, 16'd1);
    apply_sample(rnd_sample());
    apply_sample(rnd_sample());
    idle(3);

    apply_start(CFG_3210, 16'd0);
    idle(2);
    check_output("len0_busy", busy, 0);
    apply_start({NC{6'd1}}, 16'd3);
    apply_sample(rnd_sample());
    apply_start('0, 16'd10);
    for (int n = 0; n < 6; n++) apply_sample(rnd_sample());
    idle(3);

    for (int line = 0; line < 4; line++) begin
      int guard;
      logic [NC*KW-1:0] cfg;
      cfg = NC*KW'({$urandom, $urandom});
      apply_start(cfg, 16'($urandom_range(1, 20)));
      guard = 0;
      while (m_active && guard < 200) begin
        apply_sample(rnd_sample());
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        guard++;
      end
      if (m_active) check_output("line_timeout", 0, 1);
      apply_sample(rnd_sample());
      idle(3);
    end

    idle(2);
    check_output("queue_empty", exp_q.size(), 0);
    check_output("lone_queue_empty", lone_done_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/delay_align.md
Name: delay_align

Overview:
- Per-channel programmable delay stage feeding the delay-and-sum summer.
- Buffers incoming multi-channel RF samples in per-channel circular buffers and emits time-aligned samples on delayed_sample, qualified by sum_en, with a start_sum pulse marking the first aligned sample of each scan line.
- Gates output until every channel's delay line is filled, so the summer never adds stale data.

Parameters:
- DATA_WIDTH, 16, bits per channel sample
- NUM_CHANNELS, 4, number of receive channels
- MAX_DELAY, 64, buffer depth per channel in samples; power of two
- DELAY_WIDTH, $clog2(MAX_DELAY), width of one channel delay value
- LEN_WIDTH, 16, width of the line-length counter

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-low reset
- start  input  1  begin scan line; delay_cfg and line_len are sampled here
- delay_cfg  input  NUM_CHANNELS*DELAY_WIDTH  per-channel delay in samples, channel i at [i*DELAY_WIDTH +: DELAY_WIDTH]
- line_len  input  LEN_WIDTH  number of aligned output samples for this line
- sample_valid  input  1  sample_in holds a new sample set
- sample_in  input  NUM_CHANNELS*DATA_WIDTH  raw samples, channel i at [i*DATA_WIDTH +: DATA_WIDTH]
- delayed_sample  output  NUM_CHANNELS*DATA_WIDTH  aligned samples, same packing
- sum_en  output  1  delayed_sample valid this cycle
- start_sum  output  1  one-cycle pulse coincident with the first sum_en of a line
- busy  output  1  high in FILL or STREAM
- done  output  1  one-cycle pulse when the line completes

Behaviour:
- Reset (reset==0 at posedge):
  - FSM goes to IDLE.
  - delayed_sample, sum_en, start_sum, busy and done go to 0.
  - Write pointer, fill counter and output counter go to 0.
  - Buffer RAM contents are not cleared; fill gating makes this safe.
  - Reset mid-line aborts the line immediately with no done pulse.
- IDLE:
  - On start, latch delay_cfg into d[i] and line_len into len_r.
  - Clear the fill and output counters.
  - If line_len==0: pulse done next cycle and stay IDLE.
  - Else if max(d[i])==0: go to STREAM.
  - Else: go to FILL.
  - sample_valid in IDLE is ignored; no writes occur.
- start while busy: ignored.
- Delay semantics:
  - On a sample_valid at write index w, channel i outputs the sample written at index (w - d[i]) mod MAX_DELAY.
  - d[i]==0 outputs the current sample_in, using a same-cycle bypass (no RAM read-during-write hazard).
- Write:
  - Each sample_valid in FILL or STREAM writes all channels at wr_ptr.
  - wr_ptr then increments, wrapping at MAX_DELAY-1 -> 0.
- FILL:
  - Each sample_valid increments fill_cnt.
  - The sample_valid for which fill_cnt equals dmax=max(d[i]) is the first aligned sample: it is output and the FSM enters STREAM.
  - That is, the first output is produced on the (dmax+1)-th input sample.
- STREAM:
  - Each sample_valid produces one aligned output.
- Output timing:
  - Latency is 1 cycle: delayed_sample and sum_en are registered the cycle after the qualifying sample_valid.
  - sum_en is 0 on all other cycles; delayed_sample holds its last value when sum_en==0.
  - start_sum accompanies the first sum_en after start.
- Line completion:
  - The output counter increments per output.
  - On the len_r-th output: done pulses on the same cycle as that sum_en, busy drops on the next cycle, FSM returns to IDLE.
- Gaps: sample_valid gaps of any length are allowed in FILL and STREAM; state holds.
- Widths: delays are unsigned; pointer arithmetic is modulo MAX_DELAY (DELAY_WIDTH bits, natural wrap). No sample arithmetic is performed.

Decomposition:
- Shared package holds:
  - FSM state encoding: IDLE, FILL, STREAM
  - DELAY_WIDTH and LEN_WIDTH derivations
  - the channel-slice helper constants used by the summer as well
- One sub-module: delay_ram, a single-channel simple dual-port buffer (MAX_DELAY x DATA_WIDTH) with synchronous write and a combinational read address.
- Instantiate delay_ram NUM_CHANNELS times in a generate loop.
- dmax reduction and bypass muxing stay in the top level.

Test Plan:
- Setup: delay_cfg={3,2,1,0} (ch3..ch0), line_len=4, then samples n=0..9 with sample_in ch i = 16*i+n.
  - Required: first sum_en after the 4th sample.
  - Outputs: ch0=n, ch1=16+n-1, ch2=32+n-2, ch3=48+n-3 for n=3..6.
  - start_sum on the first output only; done with the 4th output; busy then low; samples 7..9 produce nothing.
- All delays 0, line_len=2:
  - FSM goes IDLE->STREAM directly.
  - Output equals input, 1 cycle late, for 2 samples; then done.
- Wrap: delays all 63, line_len=70, 133 contiguous samples:
  - Each output equals the input from 63 samples earlier across the pointer wrap.
  - done on the 70th output.
- Gaps: same as scenario 1 with 3 idle cycles between each sample_valid:
  - Identical output values.
  - sum_en only 1 cycle after each valid.
- Reset mid-STREAM after 2 outputs:
  - All outputs 0 next cycle, no done.
  - A new start with line_len=1 and delays 0 yields exactly one correct output.
- line_len=0 start:
  - done pulse, no sum_en, busy stays 0.
  - start asserted while busy is ignored: the current line's output count is unchanged.
